// File: rtl/mca_pkg.sv
// mca_pkg: shared FSM state type and counter-width helper for multi_cycle_adder
package mca_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} mca_state_t;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/multi_cycle_adder_adder.sv
// adder: combinational WIDTH-bit adder with carry in/out, used as the per-cycle chunk slice
module adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: WIDTH-bit add done CHUNK bits per clock over valid/ready handshakes; MCA_SUB_EN adds a sub port for a-b
module multi_cycle_adder
   import mca_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
`ifdef MCA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             carry_out
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("multi_cycle_adder: WIDTH must be a multiple of CHUNK");
   end
   mca_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r, b_in;
   logic             carry, c_in, c_next;
   logic [CHUNK-1:0] sum;
`ifdef MCA_SUB_EN
   // subtraction is a + ~b + 1, so the operand is inverted once at latch time
   assign b_in = sub ? ~b : b;
   assign c_in = sub | carry_in;
`else
   assign b_in = b;
   assign c_in = carry_in;
`endif
   assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
   assign out_valid = (state == DONE);
   adder #(.WIDTH(CHUNK)) u_slice (
      .a   (a_r[cnt*CHUNK +: CHUNK]),
      .b   (b_r[cnt*CHUNK +: CHUNK]),
      .cin (carry),
      .s   (sum),
      .cout(c_next)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         carry     <= 1'b0;
         s         <= '0;
         carry_out <= 1'b0;
      end else if (in_valid && in_ready) begin
         a_r   <= a;
         b_r   <= b_in;
         carry <= c_in;
         cnt   <= '0;
         state <= RUN;
      end else if (state == RUN) begin
         s[cnt*CHUNK +: CHUNK] <= sum;
         carry <= c_next;
         cnt   <= cnt + 1'b1;
         if (cnt == LAST) begin
            state     <= DONE;
            carry_out <= c_next;
         end
      end else if (state == DONE && out_ready) begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb_multi_cycle_adder: directed and random checks of multi_cycle_adder (CHUNK=4 and CHUNK=16) against an arithmetic model
module tb_multi_cycle_adder;
   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        carry_in = 1'b0, sub = 1'b0;
   logic        in_ready, out_valid, carry_out, in_ready1, out_valid1, carry_out1;
   logic [15:0] s, s1;
   logic [16:0] expv;
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .carry_in(carry_in),
`ifdef MCA_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .carry_out(carry_out)
   );
   multi_cycle_adder #(.WIDTH(16), .CHUNK(16)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a), .b(b), .carry_in(carry_in),
`ifdef MCA_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid1), .out_ready(out_ready1), .s(s1), .carry_out(carry_out1)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [16:0] model(input logic [15:0] ta, tb, input logic tc, ts);
      return ts ? {ta >= tb, ta - tb} : {1'b0, ta} + {1'b0, tb} + 17'(tc);
   endfunction
   task automatic start(input logic [15:0] ta, tb, input logic tc, ts);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      a = ta; b = tb; carry_in = tc; sub = ts; in_valid = 1'b1;
      expv = model(ta, tb, tc, ts);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   task automatic wait_done(input string tag, input int want_lat);
      int lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 40);
      chk({tag, "_latency"}, 32'(lat), 32'(want_lat));
      chk({tag, "_s"}, 32'(s), 32'(expv[15:0]));
      chk({tag, "_cout"}, 32'(carry_out), 32'(expv[16]));
   endtask
   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_after_consume", 32'(out_valid), 32'd0);
      chk("in_ready_after_consume", 32'(in_ready), 32'd1);
   endtask
   task automatic op(input string tag, input logic [15:0] ta, tb, input logic tc, ts);
      start(ta, tb, tc, ts);
      wait_done(tag, 4);
      consume();
   endtask
   initial begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_s", 32'(s), 32'd0);
      chk("reset_cout", 32'(carry_out), 32'd0);
      reset = 1'b0;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      op("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
      op("ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      op("c000", 16'hC000, 16'h7000, 1'b0, 1'b0);
      // stall in DONE while a competing operand set is offered and must be ignored
      start(16'hE000, 16'hE000, 1'b1, 1'b0);
      wait_done("e000", 4);
      chk("e000_model", 32'(expv), 32'h1C001);
      a = 16'h1234; b = 16'h0001; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_s", 32'(s), 32'h0000C001);
         chk("stall_cout", 32'(carry_out), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      consume();
      // back-to-back: consume and accept on the same edge
      start(16'h0100, 16'h0200, 1'b0, 1'b0);
      wait_done("pre_b2b", 4);
      a = 16'h0001; b = 16'h0001; carry_in = 1'b0; sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_out_valid_drop", 32'(out_valid), 32'd0);
      expv = model(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_done("b2b", 4);
      consume();
      // asynchronous reset two cycles into RUN
      start(16'h1234, 16'h4321, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midreset_out_valid", 32'(out_valid), 32'd0);
      chk("midreset_s", 32'(s), 32'd0);
      chk("midreset_cout", 32'(carry_out), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("midreset_in_ready", 32'(in_ready), 32'd1);
      op("after_reset", 16'h8001, 16'h7FFF, 1'b1, 1'b0);
      // CHUNK == WIDTH: single-cycle RUN
      chk("c16_in_ready", 32'(in_ready1), 32'd1);
      a = 16'hABCD; b = 16'h6543; carry_in = 1'b1; sub = 1'b0; in_valid1 = 1'b1;
      expv = model(16'hABCD, 16'h6543, 1'b1, 1'b0);
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      chk("c16_out_valid", 32'(out_valid1), 32'd0);
      @(posedge clk); #1;
      chk("c16_latency", 32'(out_valid1), 32'd1);
      chk("c16_s", 32'(s1), 32'(expv[15:0]));
      chk("c16_cout", 32'(carry_out1), 32'(expv[16]));
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      chk("c16_consumed", 32'(out_valid1), 32'd0);
`ifdef MCA_SUB_EN
      op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
      chk("sub_neg_model", 32'(expv), 32'h0FFFE);
      op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1);
      chk("sub_pos_model", 32'(expv), 32'h10002);
`endif
      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(1));
         rs = 1'b0;
`ifdef MCA_SUB_EN
         rs = 1'($urandom_range(1));
`endif
         op("random", ra, rb, rc, rs);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
